// File: rtl/instruction_fetcher_if.sv
// Program-memory read channel between the instruction fetcher and the
// program-memory controller.
//   mem_read_valid   : read request asserted by the fetcher
//   mem_read_address : address of the request, stable while valid
//   mem_read_ready   : controller returns data this cycle
//   mem_read_data    : instruction word, qualified by mem_read_ready
// master = fetcher side, slave = memory-controller side.
interface instruction_fetcher_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data
  );
endinterface

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: latches pc on a scheduler request, issues a single
// read to program memory, then holds the returned word for the decoder
// until it is accepted. Flush abandons an in-flight or held fetch.
// Ports:
//   clk, reset       : clock, async active-low reset
//   fetch_req, pc    : scheduler fetch request and program counter
//   flush            : branch redirect, abandon current fetch
//   mem              : program-memory read channel (master side)
//   instruction      : held instruction word for the decoder
//   instr_valid      : instruction holds valid data
//   instr_accept     : decoder consumes the instruction
//   busy             : fetcher not idle
//   stall_cycles     : saturating count of cycles spent waiting on memory
module instruction_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int STALL_CNT_BITS        = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fetch_req,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc,
  input  logic                             flush,
  instruction_fetcher_if.master            mem,
  input  logic                             instr_accept,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             instr_valid,
  output logic                             busy,
  output logic [STALL_CNT_BITS-1:0]        stall_cycles
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

  state_e                            state_q, state_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]  addr_q, addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0]  instr_q, instr_d;
  logic                              rvalid_q, rvalid_d;
  logic                              ivalid_q, ivalid_d;
  logic                              discard_q, discard_d;
  logic [STALL_CNT_BITS-1:0]         stall_q, stall_d;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      instr_q   <= '0;
      rvalid_q  <= 1'b0;
      ivalid_q  <= 1'b0;
      discard_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      rvalid_q  <= rvalid_d;
      ivalid_q  <= ivalid_d;
      discard_q <= discard_d;
      stall_q   <= stall_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    rvalid_d  = rvalid_q;
    ivalid_d  = ivalid_q;
    discard_d = discard_q;
    stall_d   = stall_q;
    case (state_q)
      IDLE: begin
        if (!flush && fetch_req) begin
          addr_d   = pc;
          rvalid_d = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (stall_q != '1) stall_d = stall_q + 1'b1;
        // The request cannot be withdrawn, so a flush is only remembered
        // and the returning data is dropped when it arrives.
        if (flush) discard_d = 1'b1;
        if (mem.mem_read_ready) begin
          rvalid_d  = 1'b0;
          discard_d = 1'b0;
          if (discard_q || flush) begin
            state_d = IDLE;
          end else begin
            instr_d  = mem.mem_read_data;
            ivalid_d = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          ivalid_d = 1'b0;
          state_d  = IDLE;
        end else if (instr_accept && fetch_req) begin
          ivalid_d = 1'b0;
          addr_d   = pc;
          rvalid_d = 1'b1;
          state_d  = REQ;
        end else if (instr_accept) begin
          ivalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs, all driven straight from registers
  always_comb begin
    mem.mem_read_valid   = rvalid_q;
    mem.mem_read_address = addr_q;
    instruction          = instr_q;
    instr_valid          = ivalid_q;
    busy                 = (state_q != IDLE);
    stall_cycles         = stall_q;
  end

endmodule
